r_alu_exec: RTL and testbench

R-type execute unit for the control/datapath boundary. It sits directly downstream of the R-type funct3 decoder and consumes that decoder's one-hot function-select lines together with the register operands. It produces a registered result under a valid/ready handshake. Non-shift ops complete in one cycle; shifts run iteratively, one bit per cycle, unless the barrel-shift option is compiled in.

---
 rtl/r_alu_exec.sv | 153 +++++++++++++++
 tb/tb_r_alu_exec.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/r_alu_exec.sv
// rtl/r_alu_exec.sv - R-type execute unit: one-hot op select, registered result, valid/ready handshake.
// Optional R_ALU_BARREL_SHIFT_EN: single-cycle barrel shifts instead of the one-bit-per-cycle shifter.
module r_alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       op_sel,
    input  logic             alt,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic [4:0]       rd_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out,
    output logic             out_err
);

    localparam int SW = $clog2(WIDTH);

`ifdef R_ALU_BARREL_SHIFT_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       rd_q, rd_d;
    logic             err_q, err_d;
`ifndef R_ALU_BARREL_SHIFT_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;
`endif

    logic             legal;
    logic [SW-1:0]    amt;
    logic [WIDTH-1:0] alu_res;

    assign legal     = (op_sel != 8'd0) && ((op_sel & (op_sel - 8'd1)) == 8'd0);
    assign amt       = rs2[SW-1:0];
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign rd_out    = rd_q;
    assign out_err   = err_q;

    always_comb begin
        alu_res = '0;
        case (op_sel)
            8'h01:   alu_res = alt ? (rs1 - rs2) : (rs1 + rs2);
            8'h04:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(rs1) < $signed(rs2))};
            8'h08:   alu_res = {{(WIDTH-1){1'b0}}, (rs1 < rs2)};
            8'h10:   alu_res = rs1 ^ rs2;
            8'h40:   alu_res = rs1 | rs2;
            8'h80:   alu_res = rs1 & rs2;
`ifdef R_ALU_BARREL_SHIFT_EN
            8'h02:   alu_res = rs1 << amt;
            8'h20:   alu_res = alt ? WIDTH'($signed(rs1) >>> amt) : (rs1 >> amt);
`endif
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        rd_d     = rd_q;
        err_d    = err_q;
`ifndef R_ALU_BARREL_SHIFT_EN
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        arith_d  = arith_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rd_d    = rd_in;
                    state_d = S_DONE;
                    if (!legal) begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end else begin
                        err_d    = 1'b0;
                        result_d = alu_res;
`ifndef R_ALU_BARREL_SHIFT_EN
                        if (op_sel[1] || op_sel[5]) begin
                            acc_d    = rs1;
                            cnt_d    = amt;
                            left_d   = op_sel[1];
                            arith_d  = op_sel[5] & alt;
                            result_d = rs1;
                            if (amt != '0) begin
                                result_d = result_q;
                                state_d  = S_SHIFT;
                            end
                        end
`endif
                    end
                end
            end
`ifndef R_ALU_BARREL_SHIFT_EN
            S_SHIFT: begin
                // Right shifts fill with the sign bit only for SRA.
                acc_d = left_q ? {acc_q[WIDTH-2:0], 1'b0}
                               : {arith_q & acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SW'(1)) begin
                    result_d = acc_d;
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
`ifndef R_ALU_BARREL_SHIFT_EN
            acc_q    <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
`ifndef R_ALU_BARREL_SHIFT_EN
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
`endif
        end
    end

endmodule

// File: tb/tb_r_alu_exec.sv
// tb/tb_r_alu_exec.sv - self-checking bench for r_alu_exec against a behavioural reference model.
module tb_r_alu_exec;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   op_sel;
    logic         alt;
    logic [W-1:0] rs1;
    logic [W-1:0] rs2;
    logic [4:0]   rd_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   rd_out;
    logic         out_err;

    int total = 0;
    int bad   = 0;

    r_alu_exec #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_sel(op_sel), .alt(alt), .rs1(rs1), .rs2(rs2), .rd_in(rd_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .rd_out(rd_out), .out_err(out_err)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [7:0] sel);
        int n = 0;
        for (int i = 0; i < 8; i++) if (sel[i]) n++;
        return n == 1;
    endfunction

    function automatic logic [W-1:0] model(input logic [7:0] sel, input bit a,
                                           input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned sh = y % W;
        longint sx = $signed(x);
        longint sy = $signed(y);
        if (!is_legal(sel)) return '0;
        case (sel)
            8'h01: return a ? W'(x - y) : W'(x + y);
            8'h02: return W'(x * (64'd1 << sh));
            8'h04: return (sx < sy) ? 1 : 0;
            8'h08: return (x < y) ? 1 : 0;
            8'h10: return x ^ y;
            8'h20: return a ? W'(sx >>> sh) : W'(x / (64'd1 << sh));
            8'h40: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic int model_lat(input logic [7:0] sel, input logic [W-1:0] y);
`ifdef R_ALU_BARREL_SHIFT_EN
        return 1;
`else
        if (is_legal(sel) && (sel == 8'h02 || sel == 8'h20) && (y % W) != 0) return (y % W) + 1;
        return 1;
`endif
    endfunction

    // Drives one op from the post-edge phase, measures latency, then releases the result.
    task automatic do_op(input logic [7:0] sel, input bit a, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [4:0] rd,
                         output logic [W-1:0] res, output logic err, output logic [4:0] rdo,
                         output int lat, output bit busy_rdy, output bit idle_ok);
        busy_rdy = 1'b0;
        op_sel = sel; alt = a; rs1 = x; rs2 = y; rd_in = rd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rs1 = $urandom; rs2 = $urandom; op_sel = 8'($urandom); rd_in = 5'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) busy_rdy = 1'b1;
        res = result; err = out_err; rdo = rd_out;
        out_ready = 1'b1;
        @(posedge clk); #1;
        idle_ok = in_ready && !out_valid;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        total++;
        if ({result, rd_out, out_err} !== '0) begin
            bad++; $display("FAIL reset_outputs result=%h rd=%0d err=%0b want all 0", result, rd_out, out_err);
        end
    endtask

    task automatic test_directed;
        logic [7:0]   sels [7] = '{8'h01, 8'h01, 8'h04, 8'h08, 8'h20, 8'h02, 8'h03};
        bit           alts [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] as   [7] = '{32'd5, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'd9};
        logic [W-1:0] bs   [7] = '{32'd7, 32'd5, 32'd1, 32'd1, 32'h24, 32'h40, 32'd9};
        logic [W-1:0] want [7] = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h12345678, 32'd0};
        logic [W-1:0] res; logic err; logic [4:0] rdo; int lat; bit br, idl;
        for (int i = 0; i < 7; i++) begin
            do_op(sels[i], alts[i], as[i], bs[i], 5'(i + 3), res, err, rdo, lat, br, idl);
            total++;
            if (res !== want[i] || rdo !== 5'(i + 3) || err !== (i == 6)) begin
                bad++;
                $display("FAIL directed_%0d result=%h rd=%0d err=%0b want result=%h rd=%0d err=%0b",
                         i, res, rdo, err, want[i], i + 3, (i == 6));
            end
            total++;
            if (lat != model_lat(sels[i], bs[i]) || br) begin
                bad++;
                $display("FAIL directed_lat_%0d lat=%0d busy_ready=%0b want lat=%0d busy_ready=0",
                         i, lat, br, model_lat(sels[i], bs[i]));
            end
        end
    endtask

    task automatic test_random;
        logic [7:0] illegal [5] = '{8'h00, 8'h03, 8'hFF, 8'h81, 8'h24};
        logic [W-1:0] res; logic err; logic [4:0] rdo; int lat; bit br, idl;
        for (int n = 0; n < 60; n++) begin
            logic [7:0] sel = ($urandom_range(0, 7) == 0) ? illegal[$urandom_range(0, 4)]
                                                          : 8'(1 << $urandom_range(0, 7));
            bit a = 1'($urandom);
            logic [W-1:0] x = $urandom;
            logic [W-1:0] y = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 100));
            logic [4:0] rd = 5'($urandom);
            do_op(sel, a, x, y, rd, res, err, rdo, lat, br, idl);
            total++;
            if (res !== model(sel, a, x, y) || err !== !is_legal(sel) || rdo !== rd ||
                lat != model_lat(sel, y) || br || !idl) begin
                bad++;
                $display("FAIL random_%0d sel=%h alt=%0b a=%h b=%h got res=%h err=%0b rd=%0d lat=%0d br=%0b idle=%0b want res=%h err=%0b rd=%0d lat=%0d",
                         n, sel, a, x, y, res, err, rdo, lat, br, idl,
                         model(sel, a, x, y), !is_legal(sel), rd, model_lat(sel, y));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] held;
        op_sel = 8'h10; alt = 1'b0; rs1 = 32'hA5A5_0F0F; rs2 = 32'h0FF0_FFFF; rd_in = 5'd17; in_valid = 1'b1;
        @(posedge clk); #1;
        rs1 = 32'd1; rs2 = 32'd1; op_sel = 8'h01; rd_in = 5'd2;
        held = 32'hA5A5_0F0F ^ 32'h0FF0_FFFF;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (out_valid !== 1'b1 || result !== held || rd_out !== 5'd17 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL backpressure_%0d valid=%0b res=%h rd=%0d in_ready=%0b want 1 %h 17 0",
                         c, out_valid, result, rd_out, in_ready, held);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL backpressure_release in_ready=%0b valid=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [W-1:0] res; logic err; logic [4:0] rdo; int lat; bit br, idl;
        op_sel = 8'h02; alt = 1'b0; rs1 = 32'h1; rs2 = 32'd20; rd_in = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0 || rd_out !== '0) begin
            bad++;
            $display("FAIL reset_mid_shift valid=%0b in_ready=%0b res=%h rd=%0d want 0 1 0 0",
                     out_valid, in_ready, result, rd_out);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        do_op(8'h01, 1'b0, 32'd1, 32'd1, 5'd4, res, err, rdo, lat, br, idl);
        total++;
        if (res !== 32'd2 || lat != 1 || err !== 1'b0 || rdo !== 5'd4) begin
            bad++; $display("FAIL post_reset_add res=%h lat=%0d err=%0b rd=%0d want 2 1 0 4", res, lat, err, rdo);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_sel = '0; alt = 1'b0;
        rs1 = '0; rs2 = '0; rd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        @(posedge clk); #1;
        test_directed;
        test_random;
        test_backpressure;
        test_reset_mid_shift;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
